// File: rtl/isqrt_seq.sv
// Sequential non-restoring integer square root, one root bit per clock, start/done handshake.
// Define SQRT_ROUND_EN to add a ROUND state that rounds the root to nearest (saturating).
module isqrt_seq #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   radicand,
   output logic               busy,
   output logic               done,
   output logic [WIDTH/2-1:0] root,
   output logic [WIDTH/2:0]   remainder
);

   localparam int R  = WIDTH / 2;
   localparam int CW = (R > 1) ? $clog2(R) : 1;

`ifdef SQRT_ROUND_EN
   typedef enum logic [1:0] {IDLE, CALC, FIX, ROUND} state_t;
`else
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rad_q, rad_d;
   logic [R-1:0]     q_q, q_d;
   logic [R+1:0]     r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [R-1:0]     root_q, root_d;
   logic [R:0]       rem_q, rem_d;

   logic [R+1:0]     r_sh;
   logic [R+1:0]     r_it;
   logic [R+1:0]     r_fix;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rad_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         root_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rad_q   <= rad_d;
         q_q     <= q_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         root_q  <= root_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rad_d   = rad_q;
      q_d     = q_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      root_d  = root_q;
      rem_d   = rem_q;

      // The partial remainder is modular in R+2 bits; sign of the previous value picks add or subtract.
      r_sh  = {r_q[R-1:0], rad_q[WIDTH-1:WIDTH-2]};
      r_it  = r_q[R+1] ? (r_sh + {q_q, 2'b11}) : (r_sh - {q_q, 2'b01});
      r_fix = r_q[R+1] ? (r_q + {1'b0, q_q, 1'b1}) : r_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               rad_d   = radicand;
               q_d     = '0;
               r_d     = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            r_d   = r_it;
            q_d   = {q_q[R-2:0], ~r_it[R+1]};
            rad_d = {rad_q[WIDTH-3:0], 2'b00};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(R - 1)) begin
               cnt_d   = '0;
               state_d = FIX;
            end
         end
`ifdef SQRT_ROUND_EN
         FIX: begin
            r_d     = r_fix;
            state_d = ROUND;
         end
         ROUND: begin
            rem_d = r_q[R:0];
            if ((r_q[R:0] > {1'b0, q_q}) && !(&q_q)) begin
               root_d = q_q + R'(1);
            end else begin
               root_d = q_q;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
`else
         FIX: begin
            r_d     = r_fix;
            root_d  = q_q;
            rem_d   = r_fix[R:0];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign root      = root_q;
   assign remainder = rem_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Directed bench for isqrt_seq: WIDTH=16 and WIDTH=8 instances, expected values computed by hand,
// plus an exhaustive WIDTH=8 sweep against a search-based floor-sqrt reference.
module tb_isqrt_seq;

`ifdef SQRT_ROUND_EN
   localparam int LAT16 = 11;
   localparam int LAT8  = 7;
   localparam logic [7:0] EXP143   = 8'd12;
   localparam logic [7:0] EXP1000  = 8'd32;
   localparam int         ROUND_ON = 1;
`else
   localparam int LAT16 = 10;
   localparam int LAT8  = 6;
   localparam logic [7:0] EXP143   = 8'd11;
   localparam logic [7:0] EXP1000  = 8'd31;
   localparam int         ROUND_ON = 0;
`endif

   logic        clk;
   logic        rst_n;
   logic        start16;
   logic [15:0] rad16;
   logic        busy16;
   logic        done16;
   logic [7:0]  root16;
   logic [8:0]  rem16;
   logic        start8;
   logic [7:0]  rad8;
   logic        busy8;
   logic        done8;
   logic [3:0]  root8;
   logic [4:0]  rem8;

   int checks;
   int failures;

   isqrt_seq #(.WIDTH(16)) dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start16),
      .radicand  (rad16),
      .busy      (busy16),
      .done      (done16),
      .root      (root16),
      .remainder (rem16)
   );

   isqrt_seq #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start8),
      .radicand  (rad8),
      .busy      (busy8),
      .done      (done8),
      .root      (root8),
      .remainder (rem8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one request on the 16-bit unit and waits (bounded) for done; lat counts edges from E0.
   task automatic run16(input logic [15:0] v, output logic [7:0] rt, output logic [8:0] rm,
                        output logic bz, output int lat);
      @(negedge clk);
      start16 = 1'b1;
      rad16   = v;
      lat     = 0;
      do begin
         @(negedge clk);
         lat++;
         start16 = 1'b0;
         rad16   = 16'hA5A5;
      end while (!done16 && lat < 100);
      rt = root16;
      rm = rem16;
      bz = busy16;
   endtask

   task automatic run8(input logic [7:0] v, output logic [3:0] rt, output logic [4:0] rm,
                       output int lat);
      @(negedge clk);
      start8 = 1'b1;
      rad8   = v;
      lat    = 0;
      do begin
         @(negedge clk);
         lat++;
         start8 = 1'b0;
         rad8   = 8'h5A;
      end while (!done8 && lat < 100);
      rt = root8;
      rm = rem8;
   endtask

   task automatic test_reset;
      rst_n   = 1'b0;
      start16 = 1'b0;
      rad16   = '0;
      start8  = 1'b0;
      rad8    = '0;
      #12;
      checks++;
      if ({busy16, done16, root16, rem16} !== 19'd0) begin
         failures++;
         $display("[TB] FAIL reset16: busy=%b done=%b root=%0d rem=%0d, required all 0", busy16, done16, root16, rem16);
      end
      checks++;
      if ({busy8, done8, root8, rem8} !== 11'd0) begin
         failures++;
         $display("[TB] FAIL reset8: busy=%b done=%b root=%0d rem=%0d, required all 0", busy8, done8, root8, rem8);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_zero;
      logic [7:0] rt;
      logic [8:0] rm;
      logic       bz;
      int         lat;
      run16(16'd0, rt, rm, bz, lat);
      checks++;
      if (lat !== LAT16) begin
         failures++;
         $display("[TB] FAIL zero_latency: got %0d edges, required %0d", lat, LAT16);
      end
      checks++;
      if (rt !== 8'd0 || rm !== 9'd0) begin
         failures++;
         $display("[TB] FAIL zero_result: root=%0d rem=%0d, required 0/0", rt, rm);
      end
      checks++;
      if (bz !== 1'b0) begin
         failures++;
         $display("[TB] FAIL zero_busy_at_done: busy=%b, required 0", bz);
      end
      @(negedge clk);
      checks++;
      if (done16 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL done_one_cycle: done=%b, required 0", done16);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      @(negedge clk);
      start16 = 1'b1;
      rad16   = 16'd144;
      lat     = 0;
      do begin
         @(negedge clk);
         lat++;
         rad16 = 16'd143;
      end while (!done16 && lat < 100);
      checks++;
      if (lat !== LAT16 || root16 !== 8'd12 || rem16 !== 9'd0) begin
         failures++;
         $display("[TB] FAIL b2b_144: lat=%0d root=%0d rem=%0d, required %0d/12/0", lat, root16, rem16, LAT16);
      end
      @(negedge clk);
      start16 = 1'b0;
      rad16   = 16'd0;
      lat     = 1;
      checks++;
      if (busy16 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_no_gap: busy=%b, required 1", busy16);
      end
      while (!done16 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== LAT16 || root16 !== EXP143 || rem16 !== 9'd22) begin
         failures++;
         $display("[TB] FAIL b2b_143: lat=%0d root=%0d rem=%0d, required %0d/%0d/22", lat, root16, rem16, LAT16, EXP143);
      end
   endtask

   task automatic test_max;
      logic [7:0] rt;
      logic [8:0] rm;
      logic       bz;
      int         lat;
      logic [3:0] rt8;
      logic [4:0] rm8;
      run16(16'hFFFF, rt, rm, bz, lat);
      checks++;
      if (rt !== 8'd255 || rm !== 9'd510 || lat !== LAT16) begin
         failures++;
         $display("[TB] FAIL max16: root=%0d rem=%0d lat=%0d, required 255/510/%0d", rt, rm, lat, LAT16);
      end
      run8(8'hFF, rt8, rm8, lat);
      checks++;
      if (rt8 !== 4'd15 || rm8 !== 5'd30 || lat !== LAT8) begin
         failures++;
         $display("[TB] FAIL max8: root=%0d rem=%0d lat=%0d, required 15/30/%0d", rt8, rm8, lat, LAT8);
      end
   endtask

   task automatic test_start_while_busy;
      int         ndone;
      int         done_at;
      logic [7:0] rt;
      logic [8:0] rm;
      @(negedge clk);
      start16 = 1'b1;
      rad16   = 16'd200;
      ndone   = 0;
      done_at = 0;
      rt      = '0;
      rm      = '0;
      for (int i = 1; i <= LAT16 + 6; i++) begin
         @(negedge clk);
         start16 = (i == 2 || i == 4 || i == LAT16 - 1);
         rad16   = 16'(i * 4567 + 9);
         if (done16) begin
            ndone++;
            done_at = i;
            rt      = root16;
            rm      = rem16;
         end
      end
      checks++;
      if (ndone !== 1 || done_at !== LAT16) begin
         failures++;
         $display("[TB] FAIL busy_ignore_count: dones=%0d at edge %0d, required 1 at %0d", ndone, done_at, LAT16);
      end
      checks++;
      if (rt !== 8'd14 || rm !== 9'd4) begin
         failures++;
         $display("[TB] FAIL busy_ignore_result: root=%0d rem=%0d, required 14/4", rt, rm);
      end
   endtask

   task automatic test_reset_midcalc;
      logic [7:0] rt;
      logic [8:0] rm;
      logic       bz;
      int         lat;
      @(negedge clk);
      start16 = 1'b1;
      rad16   = 16'd1000;
      repeat (4) begin
         @(negedge clk);
         start16 = 1'b0;
      end
      checks++;
      if (busy16 !== 1'b1 || root16 !== 8'd14) begin
         failures++;
         $display("[TB] FAIL midcalc_hold: busy=%b root=%0d, required 1/14", busy16, root16);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy16, done16, root16, rem16} !== 19'd0) begin
         failures++;
         $display("[TB] FAIL midcalc_reset: busy=%b done=%b root=%0d rem=%0d, required all 0", busy16, done16, root16, rem16);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run16(16'd1000, rt, rm, bz, lat);
      checks++;
      if (rt !== EXP1000 || rm !== 9'd39 || lat !== LAT16) begin
         failures++;
         $display("[TB] FAIL after_reset: root=%0d rem=%0d lat=%0d, required %0d/39/%0d", rt, rm, lat, EXP1000, LAT16);
      end
   endtask

   task automatic test_sweep8;
      logic [3:0] rt;
      logic [4:0] rm;
      int         lat;
      int         fl;
      int         exp_rem;
      int         exp_root;
      for (int v = 0; v < 256; v++) begin
         fl = 0;
         while ((fl + 1) * (fl + 1) <= v) fl++;
         exp_rem  = v - fl * fl;
         exp_root = (ROUND_ON != 0 && exp_rem > fl && fl < 15) ? fl + 1 : fl;
         run8(8'(v), rt, rm, lat);
         checks++;
         if (int'(rt) !== exp_root || int'(rm) !== exp_rem || lat !== LAT8
             || fl * fl + int'(rm) !== v || int'(rm) > 2 * fl) begin
            failures++;
            $display("[TB] FAIL sweep8 v=%0d: root=%0d rem=%0d lat=%0d, required %0d/%0d/%0d", v, rt, rm, lat, exp_root, exp_rem, LAT8);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_zero();
      test_back_to_back();
      test_max();
      test_start_while_busy();
      test_reset_midcalc();
      test_sweep8();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
